morse_char_fifo: RTL
====================

# morse_char_fifo

Parametrised Morse character assembler and output buffer that sits between the Morse timing decoder, which supplies dot/dash/letter-gap/word-gap pulses, and the display or readout logic. It shifts elements into a symbol of up to MAX_LEN elements. On a gap it translates the symbol to ASCII through an internal lookup, inserts a single space on word gaps, and buffers the bytes in a first-word-fall-through FIFO. Beyond the fixed 5-element/one-FIFO arrangement, it adds configurable symbol length and depth, error-character substitution, space de-duplication and a sticky overflow flag.

## Interface
- MAX_LEN, 6, maximum elements per symbol (2..7)
- DEPTH, 16, FIFO entries (power of two, ≥2)
- ERR_CHAR, 8'h2A, byte written for unknown or overlong symbols
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  one clock; reset is asynchronous and active-low
- dot, dash, lg, wg  in  1 each  single-cycle pulses from the Morse decoder
- rd_en  in  1  pop head entry
- clr_overflow  in  1  clears overflow
- dout  out  8  head entry (valid while empty=0)
- empty, full  out  1 each  FIFO status
- count  out  $clog2(DEPTH)+1  entries stored
- sym_bits  out  MAX_LEN  current symbol, dash=1
- sym_len  out  3  elements in current symbol
- overflow  out  1  sticky: a byte was dropped

## Operation
- Reset values: sym_bits=0, sym_len=0, count=0, empty=1, full=0, overflow=0, dout=0, last_was_space=1, state IDLE.
- Element: exactly one of dot or dash high. sym_bits <= {sym_bits[MAX_LEN-2:0], dash} and sym_len++. The first element lands at bit sym_len-1. Dot and dash both high is ignored.
- Overlong: an element arriving with sym_len==MAX_LEN sets the internal err flag. sym_bits and sym_len then freeze until the next gap.
- Lookup (combinational on sym_len, sym_bits):
  - A–Z → 0x41–0x5A and 0–9 → 0x30–0x39 in standard ITU codes. Examples: E=len1 b0, T=len1 b1, A=len2 b01, 5=len5 b00000, 0=len5 b11111.
  - Any other code, or err set → ERR_CHAR.
- State machine:
  - IDLE: on lg or wg, go to EMIT_CHAR. If lg and wg are both high, treat as wg.
  - On the gap edge, latch the lookup result into the pending register and the gap type. Clear sym_bits, sym_len and err.
  - If sym_len was 0 at the gap, nothing is pending. lg goes back to IDLE; wg goes to EMIT_SPACE.
  - EMIT_CHAR: push the pending byte and clear last_was_space. Go to EMIT_SPACE if the gap was wg, else to IDLE.
  - EMIT_SPACE: push 0x20 only if last_was_space=0, then set last_was_space. Go to IDLE.
- Elements are accepted in every state. A dot or dash on the same edge as a gap starts the new symbol after the clear. A gap arriving in EMIT_CHAR or EMIT_SPACE is queued (one deep) and processed on return to IDLE.
- FIFO:
  - A push is accepted if full=0, or if a pop happens on the same edge.
  - A push that is not accepted is dropped, sets overflow and is not retried. overflow stays set until clr_overflow; if clr_overflow and a new drop coincide, overflow stays 1.
  - rd_en while empty is ignored. Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo DEPTH. full = (count==DEPTH).

## Timing
- Element at edge t: sym_bits and sym_len updated after t.
- lg at edge t: byte written at edge t+1. empty falls and dout is valid after t+1.
- wg at edge t with a symbol: character written at t+1, space at t+2.
- Pop at edge t: the next entry appears on dout after t; empty rises after t if count was 1.
- Asynchronous reset mid-operation returns every output to its reset value immediately; FIFO contents are discarded.

## Test plan
- Dot, dash, lg → FIFO holds 0x41 ('A'); sym_len reads 2 before the gap and 0 after; empty=0 two cycles after lg.
- Dot, wg, wg, then dash, wg → entries 0x45, 0x20, 0x54, 0x20; the second wg adds no space.
- Seven dots with MAX_LEN=6, then lg → single 0x2A; a dot on the same cycle as lg yields sym_len=1 afterwards.
- DEPTH=4: five letters with no reads → count=4, full=1, overflow=1, fifth letter lost. Then rd_en with a write on the same edge → count stays 4, overflow cleared only by clr_overflow.
- Dot, dash, dash, dash, dash, lg → 0x31 ('1'). Dash, dash, dot, dot, dash, dash, lg (len6 unknown) → 0x2A.
- Reset_n low between dash and lg → sym_len=0, empty=1 immediately; a subsequent lg produces no write.

Source files
------------

// File: rtl/morse_char_fifo.sv
// morse_char_fifo
//   Collects dot/dash pulses from the Morse timing decoder into a symbol,
//   translates the symbol to ASCII when a letter gap (lg) or word gap (wg)
//   arrives, adds one space per word gap (never two in a row), and buffers
//   the bytes in a first-word-fall-through FIFO for the display logic.
//
// Parameters
//   MAX_LEN  : maximum elements per symbol (2..7)
//   DEPTH    : FIFO entries (power of two, >= 2)
//   ERR_CHAR : byte written for unknown or overlong symbols
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   dot, dash, lg, wg       : single-cycle pulses from the decoder
//   rd_en                   : pop the head entry (ignored while empty)
//   clr_overflow            : clear the sticky overflow flag
//   dout                    : head entry, 0 while empty
//   empty, full, count      : FIFO status
//   sym_bits, sym_len       : symbol being assembled (dash = 1)
//   overflow                : sticky, a byte was dropped on a full FIFO
module morse_char_fifo #(
  parameter int         MAX_LEN  = 6,
  parameter int         DEPTH    = 16,
  parameter logic [7:0] ERR_CHAR = 8'h2A
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dot,
  input  logic                     dash,
  input  logic                     lg,
  input  logic                     wg,
  input  logic                     rd_en,
  input  logic                     clr_overflow,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [MAX_LEN-1:0]       sym_bits,
  output logic [2:0]               sym_len,
  output logic                     overflow
);

  localparam int         AW        = $clog2(DEPTH);
  localparam int         CW        = AW + 1;
  localparam logic [2:0] MAX_LEN_L = 3'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, EMIT_CHAR, EMIT_SPACE} state_t;

  // Symbol codes are read with the first element as the most significant
  // used bit; bits above sym_len are always zero because the register is
  // cleared on every gap and filled by left shifts.
  function automatic logic [7:0] lookup(input logic [2:0] len,
                                        input logic [MAX_LEN-1:0] bits,
                                        input logic err);
    logic [4:0] code;
    logic [7:0] ch;
    code = 5'(bits);
    ch   = ERR_CHAR;
    case ({len, code})
      {3'd2, 5'b00001}: ch = 8'h41; // A
      {3'd4, 5'b01000}: ch = 8'h42; // B
      {3'd4, 5'b01010}: ch = 8'h43; // C
      {3'd3, 5'b00100}: ch = 8'h44; // D
      {3'd1, 5'b00000}: ch = 8'h45; // E
      {3'd4, 5'b00010}: ch = 8'h46; // F
      {3'd3, 5'b00110}: ch = 8'h47; // G
      {3'd4, 5'b00000}: ch = 8'h48; // H
      {3'd2, 5'b00000}: ch = 8'h49; // I
      {3'd4, 5'b00111}: ch = 8'h4A; // J
      {3'd3, 5'b00101}: ch = 8'h4B; // K
      {3'd4, 5'b00100}: ch = 8'h4C; // L
      {3'd2, 5'b00011}: ch = 8'h4D; // M
      {3'd2, 5'b00010}: ch = 8'h4E; // N
      {3'd3, 5'b00111}: ch = 8'h4F; // O
      {3'd4, 5'b00110}: ch = 8'h50; // P
      {3'd4, 5'b01101}: ch = 8'h51; // Q
      {3'd3, 5'b00010}: ch = 8'h52; // R
      {3'd3, 5'b00000}: ch = 8'h53; // S
      {3'd1, 5'b00001}: ch = 8'h54; // T
      {3'd3, 5'b00001}: ch = 8'h55; // U
      {3'd4, 5'b00001}: ch = 8'h56; // V
      {3'd3, 5'b00011}: ch = 8'h57; // W
      {3'd4, 5'b01001}: ch = 8'h58; // X
      {3'd4, 5'b01011}: ch = 8'h59; // Y
      {3'd4, 5'b01100}: ch = 8'h5A; // Z
      {3'd5, 5'b11111}: ch = 8'h30; // 0
      {3'd5, 5'b01111}: ch = 8'h31; // 1
      {3'd5, 5'b00111}: ch = 8'h32; // 2
      {3'd5, 5'b00011}: ch = 8'h33; // 3
      {3'd5, 5'b00001}: ch = 8'h34; // 4
      {3'd5, 5'b00000}: ch = 8'h35; // 5
      {3'd5, 5'b10000}: ch = 8'h36; // 6
      {3'd5, 5'b11000}: ch = 8'h37; // 7
      {3'd5, 5'b11100}: ch = 8'h38; // 8
      {3'd5, 5'b11110}: ch = 8'h39; // 9
      default:          ch = ERR_CHAR;
    endcase
    if (err) ch = ERR_CHAR;
    return ch;
  endfunction

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] sym_bits_q, sym_bits_d;
  logic [2:0]         sym_len_q, sym_len_d;
  logic               err_q, err_d;
  logic [7:0]         pend_q, pend_d;
  logic               pend_wg_q, pend_wg_d;
  logic               gapq_vld_q, gapq_vld_d;
  logic               gapq_wg_q, gapq_wg_d;
  logic               lws_q, lws_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [DEPTH];

  logic       elem, gap_in, take_gap, take_wg;
  logic       push, pop, accept, drop, full_w, empty_w;
  logic [7:0] push_data;

  always_comb begin
    elem     = dot ^ dash;
    gap_in   = lg | wg;
    // A gap held over from an EMIT state takes priority over a new one.
    take_gap = (state_q == IDLE) && (gapq_vld_q || gap_in);
    take_wg  = gapq_vld_q ? gapq_wg_q : wg;

    // Symbol assembly: the gap clear happens first so an element on the
    // same edge starts the next symbol.
    sym_bits_d = sym_bits_q;
    sym_len_d  = sym_len_q;
    err_d      = err_q;
    if (take_gap) begin
      sym_bits_d = '0;
      sym_len_d  = 3'd0;
      err_d      = 1'b0;
    end
    if (elem) begin
      if (sym_len_d == MAX_LEN_L) begin
        err_d = 1'b1;
      end else begin
        sym_bits_d = {sym_bits_d[MAX_LEN-2:0], dash};
        sym_len_d  = sym_len_d + 3'd1;
      end
    end

    // One-deep holding slot for gaps that arrive while emitting.
    gapq_vld_d = gapq_vld_q;
    gapq_wg_d  = gapq_wg_q;
    if (state_q == IDLE) begin
      if (gapq_vld_q) begin
        gapq_vld_d = gap_in;
        gapq_wg_d  = wg;
      end
    end else if (gap_in) begin
      gapq_vld_d = 1'b1;
      gapq_wg_d  = gapq_vld_q ? (gapq_wg_q | wg) : wg;
    end

    state_d   = state_q;
    pend_d    = pend_q;
    pend_wg_d = pend_wg_q;
    lws_d     = lws_q;
    push      = 1'b0;
    push_data = pend_q;
    case (state_q)
      IDLE: begin
        if (take_gap) begin
          pend_d    = lookup(sym_len_q, sym_bits_q, err_q);
          pend_wg_d = take_wg;
          if (sym_len_q != 3'd0) state_d = EMIT_CHAR;
          else if (take_wg)      state_d = EMIT_SPACE;
        end
      end
      EMIT_CHAR: begin
        push    = 1'b1;
        lws_d   = 1'b0;
        state_d = pend_wg_q ? EMIT_SPACE : IDLE;
      end
      EMIT_SPACE: begin
        if (!lws_q) begin
          push      = 1'b1;
          push_data = 8'h20;
        end
        lws_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // FIFO bookkeeping: a pop frees the slot a same-edge push needs.
    empty_w    = (count_q == '0);
    full_w     = (count_q == CW'(DEPTH));
    pop        = rd_en && !empty_w;
    accept     = push && (!full_w || pop);
    drop       = push && !accept;
    wr_ptr_d   = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (pop && !accept) count_d = count_q - CW'(1);
    overflow_d = drop | (overflow_q & ~clr_overflow);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sym_bits_q <= '0;
      sym_len_q  <= 3'd0;
      err_q      <= 1'b0;
      pend_wg_q  <= 1'b0;
      gapq_vld_q <= 1'b0;
      gapq_wg_q  <= 1'b0;
      lws_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_bits_q <= sym_bits_d;
      sym_len_q  <= sym_len_d;
      err_q      <= err_d;
      pend_wg_q  <= pend_wg_d;
      gapq_vld_q <= gapq_vld_d;
      gapq_wg_q  <= gapq_wg_d;
      lws_q      <= lws_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents are meaningless once count says so, so no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    if (accept) mem_q[wr_ptr_q] <= push_data;
  end

  assign dout     = empty_w ? 8'h00 : mem_q[rd_ptr_q];
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign sym_bits = sym_bits_q;
  assign sym_len  = sym_len_q;
  assign overflow = overflow_q;

endmodule
